display_decode_16b: RTL and testbench

DISPLAY_DECODE_16B -- requirements
Module: display_decode_16b

---
 rtl/display_decode_16b.sv | 117 +++++++++++
 tb/tb_display_decode_16b.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/display_decode_16b.sv
// Debounced decoder for four active-low 7-segment hex digits into a 16-bit value.
// Optional DISPLAY_DECODE_DP_OUT_EN adds a dp[3:0] output latched at each commit.
module display_decode_16b #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] SEG_32,
    output logic [15:0] data,
    output logic        valid,
`ifdef DISPLAY_DECODE_DP_OUT_EN
    output logic [3:0]  dp,
`endif
    output logic [3:0]  err
);

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    logic [31:0] sample_r;
    logic [7:0]  cnt_r;
    logic        commit_flag_r;
    logic        change_s;
    logic        commit_s;
    logic [15:0] data_next_s;
    logic [3:0]  err_next_s;
    logic [3:0]  dp_next_s;

    // Returns {legal, nibble} for a segment pattern; dp is not part of the input.
    function automatic logic [4:0] decode_glyph(input logic [6:0] g);
        logic [4:0] r;
        case (g)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Stability detection: the count saturates, so it only ever steps into STABLE_C once per run.
    always_comb begin
        change_s = (SEG_32 != sample_r);
        if (!change_s && (cnt_r == STABLE_C - 8'd1) && !commit_flag_r) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Per-digit decode of the held sample; illegal glyphs keep the old nibble.
    always_comb begin
        data_next_s = data;
        err_next_s  = 4'b0000;
        dp_next_s   = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            logic [4:0] dec;
            dec = decode_glyph(sample_r[8*k +: 7]);
            dp_next_s[k] = ~sample_r[8*k + 7];
            if (dec[4]) begin
                data_next_s[4*k +: 4] = dec[3:0];
                err_next_s[k]         = 1'b0;
            end else begin
                err_next_s[k]         = 1'b1;
            end
        end
    end

    // Sample, count and commit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_r      <= 32'hFFFF_FFFF;
            cnt_r         <= 8'd0;
            commit_flag_r <= 1'b0;
            data          <= 16'h0000;
            err           <= 4'b0000;
            valid         <= 1'b0;
`ifdef DISPLAY_DECODE_DP_OUT_EN
            dp            <= 4'b0000;
`endif
        end else begin
            sample_r <= SEG_32;
            valid    <= commit_s;
            if (change_s) begin
                cnt_r         <= 8'd0;
                commit_flag_r <= 1'b0;
            end else begin
                if (cnt_r != STABLE_C) begin
                    cnt_r <= cnt_r + 8'd1;
                end
                if (commit_s) begin
                    commit_flag_r <= 1'b1;
                end
            end
            if (commit_s) begin
                data <= data_next_s;
                err  <= err_next_s;
`ifdef DISPLAY_DECODE_DP_OUT_EN
                dp   <= dp_next_s;
`endif
            end
        end
    end

endmodule

// File: tb/tb_display_decode_16b.sv
// Randomized bench for display_decode_16b: two instances (STABLE_CYCLES 4 and 1) against a sliding-window model.
module tb_display_decode_16b;

    localparam int S0 = 4;
    localparam int S1 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] seg;
    logic [15:0] d0, d1;
    logic        v0, v1;
    logic [3:0]  e0, e1;
`ifdef DISPLAY_DECODE_DP_OUT_EN
    logic [3:0]  dp0, dp1;
`endif

    always #5 clk = ~clk;

    display_decode_16b #(.STABLE_CYCLES(S0)) dut0 (
        .clk(clk), .rst(rst), .SEG_32(seg), .data(d0), .valid(v0),
`ifdef DISPLAY_DECODE_DP_OUT_EN
        .dp(dp0),
`endif
        .err(e0)
    );

    display_decode_16b #(.STABLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst(rst), .SEG_32(seg), .data(d1), .valid(v1),
`ifdef DISPLAY_DECODE_DP_OUT_EN
        .dp(dp1),
`endif
        .err(e1)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0]  glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    // hist[i][0] is the newest sample; bit 32 marks "no sample" (before reset value).
    logic [32:0] hist [2][8];
    logic [15:0] m_data  [2];
    logic [3:0]  m_err   [2];
    logic [3:0]  m_dp    [2];
    logic        m_valid [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // A commit happens when the newest s+1 samples are identical and the one before differs.
    function automatic bit window_commit(input int i, input int s);
        for (int j = 0; j <= s; j++) begin
            if (hist[i][j][32] || hist[i][j] != hist[i][0]) return 1'b0;
        end
        return hist[i][s+1] != hist[i][0];
    endfunction

    task automatic model_edge(input int i, input int s);
        if (rst) begin
            for (int j = 0; j < 8; j++) hist[i][j] = {1'b1, 32'h0};
            hist[i][0] = {1'b0, 32'hFFFF_FFFF};
            m_data[i] = 16'h0; m_err[i] = 4'h0; m_dp[i] = 4'h0; m_valid[i] = 1'b0;
        end else begin
            for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = {1'b0, seg};
            m_valid[i] = window_commit(i, s);
            if (m_valid[i]) begin
                for (int k = 0; k < 4; k++) begin
                    logic [7:0] b;
                    bit hit;
                    b = seg[8*k +: 8];
                    hit = 1'b0;
                    for (int g = 0; g < 16; g++) begin
                        if (b[6:0] == glyphs[g]) begin
                            m_data[i][4*k +: 4] = 4'(g);
                            hit = 1'b1;
                        end
                    end
                    m_err[i][k] = !hit;
                    m_dp[i][k]  = ~b[7];
                end
            end
        end
    endtask

    task automatic step(input logic [31:0] v, input logic r);
        seg = v;
        rst = r;
        @(posedge clk);
        #1;
        model_edge(0, S0);
        model_edge(1, S1);
        check_val("valid_s4", {31'h0, v0}, {31'h0, m_valid[0]});
        check_val("data_s4",  {16'h0, d0}, {16'h0, m_data[0]});
        check_val("err_s4",   {28'h0, e0}, {28'h0, m_err[0]});
        check_val("valid_s1", {31'h0, v1}, {31'h0, m_valid[1]});
        check_val("data_s1",  {16'h0, d1}, {16'h0, m_data[1]});
        check_val("err_s1",   {28'h0, e1}, {28'h0, m_err[1]});
`ifdef DISPLAY_DECODE_DP_OUT_EN
        check_val("dp_s4", {28'h0, dp0}, {28'h0, m_dp[0]});
        check_val("dp_s1", {28'h0, dp1}, {28'h0, m_dp[1]});
`endif
    endtask

    task automatic hold(input logic [31:0] v, input int n);
        for (int c = 0; c < n; c++) step(v, 1'b0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] g;
            logic       b7;
            g  = 4'($urandom_range(0, 15));
            b7 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) w[8*k +: 8] = 8'($urandom);
            else                           w[8*k +: 8] = {b7, glyphs[g]};
        end
        return w;
    endfunction

    initial begin
        logic [31:0] cur;
        int pulses;
        seg = 32'h0;
        rst = 1'b1;

        step(32'h0000_0000, 1'b1);
        step(32'h0000_0000, 1'b1);
        check_val("reset_data", {16'h0, d0}, 32'h0);
        check_val("reset_valid", {31'h0, v0}, 32'h0);

        // Single pulse, four cycles after first sample.
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            step(32'hF9A4_B0C0, 1'b0);
            if (v0) pulses++;
            if (c == S0) check_val("r025_latency", {31'h0, v0}, 32'h1);
        end
        check_val("r025_pulses", 32'(pulses), 32'd1);
        check_val("r025_data", {16'h0, d0}, 32'h1230);

        pulses = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin step(32'h4040_4040, 1'b0); if (v0) pulses++; end
            for (int c = 0; c < 3; c++) begin step(32'h7979_7979, 1'b0); if (v0) pulses++; end
        end
        check_val("r026_no_valid", 32'(pulses), 32'd0);
        hold(32'h7979_7979, 6);
        check_val("r026_data", {16'h0, d0}, 32'h1111);

        hold(32'hF9A4_B0C0, 6);
        hold(32'hF9A4_FFC0, 6);
        check_val("r027_data", {16'h0, d0}, 32'h1230);
        check_val("r027_err", {28'h0, e0}, 32'h2);

        hold(32'hC0C0_C0C0, 6);
        hold(32'hC0C0_C040, 6);
        check_val("r028_data", {16'h0, d0}, 32'h0000);
`ifdef DISPLAY_DECODE_DP_OUT_EN
        check_val("r028_dp", {28'h0, dp0}, 32'h1);
`endif

        hold(32'hF9A4_B0C0, 6);
        hold(32'hA4A4_A4A4, 2);
        step(32'hA4A4_A4A4, 1'b1);
        step(32'hA4A4_A4A4, 1'b1);
        check_val("r029_reset_data", {16'h0, d0}, 32'h0);
        hold(32'hA4A4_A4A4, 6);
        check_val("r029_data", {16'h0, d0}, 32'h2222);

        // STABLE_CYCLES=1 instance: each glyph held two cycles commits once.
        for (int g = 0; g < 16; g++) begin
            cur = {4{1'b1, glyphs[g]}};
            hold(cur, 2);
        end
        check_val("r030_data", {16'h0, d1}, 32'hFFFF);

        cur = 32'hC0C0_C0C0;
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0:       cur = cur ^ 32'h8000_0000 >> (8 * $urandom_range(0, 3));
                1:       step(cur, 1'b1);
                default: cur = rand_word();
            endcase
            hold(cur, $urandom_range(1, 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
